// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-addressed little-endian RAM responder with wait states, sticky errors and access stats
module mem_responder #(
  parameter int MEM_ADDR_BITS = 10,
  parameter int WAIT_STATES   = 0
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire  [63:0] data,
  input  logic [31:0] address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  output logic        mem_ready,
  output logic        err_misalign,
  output logic        err_conflict,
  output logic        err_range,
  output logic [15:0] access_count,
  output logic [63:0] last_read
);

  localparam int DEPTH = 1 << MEM_ADDR_BITS;

  // Storage is deliberately left out of reset so the board keeps its contents across resets.
  logic [7:0] mem_q [DEPTH];

  logic                     req;
  logic                     conflict;
  logic                     is_rd;
  logic                     is_wr;
  logic                     complete;
  logic                     drive_en;
  logic                     misalign;
  logic                     out_of_range;
  logic [3:0]               nbytes;
  logic [MEM_ADDR_BITS-1:0] base;
  logic [63:0]              rd_val;

  assign conflict     = mem_read & mem_write;
  assign req          = mem_read ^ mem_write;
  assign is_rd        = mem_read & ~mem_write;
  assign is_wr        = mem_write & ~mem_read;
  assign nbytes       = 4'd1 << size;
  assign base         = address[MEM_ADDR_BITS-1:0];
  assign out_of_range = |address[31:MEM_ADDR_BITS];

  // Alignment test: the low log2(N) address bits must all be zero.
  always_comb begin
    misalign = 1'b0;
    case (size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = address[0];
      2'b10:   misalign = |address[1:0];
      default: misalign = |address[2:0];
    endcase
  end

  // Gather N bytes little-endian; byte addresses wrap inside the decoded window, upper bytes read as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(nbytes)) begin
        rd_val[8*i +: 8] = mem_q[base + MEM_ADDR_BITS'(i)];
      end
    end
  end

  if (WAIT_STATES == 0) begin : g_nowait
    assign mem_ready = req;
  end else begin : g_wait
    typedef enum logic {
      S_IDLE,
      S_WAIT
    } state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       ready_q;

    // Wait-state sequencer: count held-request edges, raise ready when the count hits WAIT_STATES.
    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= S_IDLE;
        cnt_q   <= 4'd0;
        ready_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (req) begin
              state_q <= S_WAIT;
              cnt_q   <= 4'd1;
              ready_q <= (WS == 4'd1);
            end
          end
          default: begin
            if (!req || ready_q) begin
              // Either the request was abandoned or this edge completed it.
              state_q <= S_IDLE;
              cnt_q   <= 4'd0;
              ready_q <= 1'b0;
            end else begin
              cnt_q   <= cnt_q + 4'd1;
              ready_q <= ((cnt_q + 4'd1) == WS);
            end
          end
        endcase
      end
    end

    // Gating with req keeps ready low if the initiator drops or collides on the final cycle.
    assign mem_ready = ready_q & req;
  end

  assign complete = mem_ready & ~reset;
  assign drive_en = is_rd & mem_ready;
  assign data     = drive_en ? rd_val : 64'bz;

  // Byte-lane write of the low N bytes of the bus on the completing edge.
  always_ff @(posedge clock) begin
    if (complete && is_wr) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(nbytes)) begin
          mem_q[base + MEM_ADDR_BITS'(i)] <= data[8*i +: 8];
        end
      end
    end
  end

  // Sticky error flags, access counter and captured read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_misalign <= 1'b0;
      err_conflict <= 1'b0;
      err_range    <= 1'b0;
      access_count <= 16'd0;
      last_read    <= 64'd0;
    end else begin
      if (conflict) begin
        err_conflict <= 1'b1;
      end
      if (complete) begin
        access_count <= access_count + 16'd1;
        if (misalign) begin
          err_misalign <= 1'b1;
        end
        if (out_of_range) begin
          err_range <= 1'b1;
        end
        if (is_rd) begin
          last_read <= rd_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder (zero and three wait states)
module tb_mem_responder;

  localparam int WS1 = 3;

  logic clk = 1'b0;
  logic reset;

  logic [1:0]       rd_s, wr_s, drv_s;
  logic [1:0][31:0] addr_s;
  logic [1:0][1:0]  sz_s;
  logic [1:0][63:0] wv_s;

  wire [63:0]       bus0, bus1;
  wire [1:0]        rdy, emis, econ, erng, den;
  wire [1:0][15:0]  cnt_w;
  wire [1:0][63:0]  last_w;

  assign bus0 = drv_s[0] ? wv_s[0] : 64'bz;
  assign bus1 = drv_s[1] ? wv_s[1] : 64'bz;

  mem_responder #(.MEM_ADDR_BITS(10), .WAIT_STATES(0)) u0 (
    .clock(clk), .reset(reset), .data(bus0), .address(addr_s[0]),
    .mem_read(rd_s[0]), .mem_write(wr_s[0]), .size(sz_s[0]),
    .mem_ready(rdy[0]), .err_misalign(emis[0]), .err_conflict(econ[0]),
    .err_range(erng[0]), .access_count(cnt_w[0]), .last_read(last_w[0])
  );

  mem_responder #(.MEM_ADDR_BITS(10), .WAIT_STATES(WS1)) u1 (
    .clock(clk), .reset(reset), .data(bus1), .address(addr_s[1]),
    .mem_read(rd_s[1]), .mem_write(wr_s[1]), .size(sz_s[1]),
    .mem_ready(rdy[1]), .err_misalign(emis[1]), .err_conflict(econ[1]),
    .err_range(erng[1]), .access_count(cnt_w[1]), .last_read(last_w[1])
  );

  assign den[0] = u0.drive_en;
  assign den[1] = u1.drive_en;

  always #5 clk = ~clk;

  // Reference model: a flat byte array per instance plus counters and flags.
  logic [7:0]  mm [2][1024];
  int          mcnt [2];
  bit          mis [2], con [2], rng [2];
  logic [63:0] mlast [2];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input int k, input logic [31:0] a, input logic [1:0] sz);
    logic [63:0] v;
    int n;
    v = '0;
    n = 1 << sz;
    for (int i = 0; i < n; i++) begin
      v[8*i +: 8] = mm[k][int'((a + 32'(i)) & 32'd1023)];
    end
    return v;
  endfunction

  task automatic check_state(input int k);
    chk($sformatf("count%0d", k), 64'(cnt_w[k]), 64'(16'(mcnt[k])));
    chk($sformatf("last_read%0d", k), last_w[k], mlast[k]);
    chk($sformatf("err_misalign%0d", k), 64'(emis[k]), 64'(mis[k]));
    chk($sformatf("err_conflict%0d", k), 64'(econ[k]), 64'(con[k]));
    chk($sformatf("err_range%0d", k), 64'(erng[k]), 64'(rng[k]));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; mis[k] = 0; con[k] = 0; rng[k] = 0; mlast[k] = '0;
    end
  endtask

  // One complete access: hold the request until ready, check bus data and latency, then update the model.
  task automatic access(input int k, input bit wr, input logic [31:0] a,
                        input logic [1:0] sz, input logic [63:0] wd);
    logic [63:0] exp_rd;
    int lat;
    bit done;
    int n;
    n = 1 << sz;
    exp_rd = model_read(k, a, sz);
    addr_s[k] = a; sz_s[k] = sz; wv_s[k] = wd;
    drv_s[k] = wr; wr_s[k] = wr; rd_s[k] = !wr;
    lat = 0;
    done = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      if (rdy[k]) done = 1;
      else begin
        lat++;
        @(posedge clk); #1;
      end
    end
    chk($sformatf("latency%0d", k), 64'(lat), (k == 0) ? 64'd0 : 64'(WS1));
    if (done) begin
      if (!wr) begin
        chk($sformatf("read_bus%0d a=%h", k, a), (k == 0) ? bus0 : bus1, exp_rd);
        chk($sformatf("drive_en%0d", k), 64'(den[k]), 64'd1);
      end
      @(posedge clk); #1;
    end
    rd_s[k] = 0; wr_s[k] = 0; drv_s[k] = 0;
    if (done) begin
      if (wr) begin
        for (int i = 0; i < n; i++) mm[k][int'((a + 32'(i)) & 32'd1023)] = wd[8*i +: 8];
      end else begin
        mlast[k] = exp_rd;
      end
      mcnt[k]++;
      if ((a % 32'(n)) != 0) mis[k] = 1;
      if (a >= 32'd1024) rng[k] = 1;
    end
    check_state(k);
  endtask

  task automatic conflict(input int k);
    addr_s[k] = 32'h8; sz_s[k] = 2'b11; drv_s[k] = 0;
    rd_s[k] = 1; wr_s[k] = 1;
    @(negedge clk);
    chk($sformatf("conflict_ready%0d", k), 64'(rdy[k]), 64'd0);
    chk($sformatf("conflict_drive%0d", k), 64'(den[k]), 64'd0);
    @(posedge clk); #1;
    rd_s[k] = 0; wr_s[k] = 0;
    con[k] = 1;
    check_state(k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] wd;
    logic [31:0] a;
    logic [1:0]  sz;
    int k;
    bit wr;

    rd_s = '0; wr_s = '0; drv_s = '0; addr_s = '0; sz_s = '0; wv_s = '0;
    reset = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      check_state(j);
      chk($sformatf("reset_ready%0d", j), 64'(rdy[j]), 64'd0);
      chk($sformatf("reset_drive%0d", j), 64'(den[j]), 64'd0);
    end
    @(posedge clk); #1;

    // Doubleword write then read back, no wait states.
    access(0, 1, 32'h10, 2'b11, 64'h1122334455667788);
    access(0, 0, 32'h10, 2'b11, 64'd0);
    chk("t1_last", last_w[0], 64'h1122334455667788);
    chk("t1_count", 64'(cnt_w[0]), 64'd2);

    // Byte write into the middle, then word and half reads over it.
    access(0, 1, 32'h13, 2'b00, 64'hAB);
    access(0, 0, 32'h10, 2'b10, 64'd0);
    chk("t2_word", last_w[0], 64'h00000000AB667788);
    access(0, 0, 32'h12, 2'b01, 64'd0);
    chk("t2_half", last_w[0], 64'h000000000000AB66);
    chk("t2_misalign", 64'(emis[0]), 64'd0);

    // Give both memories known contents.
    for (int j = 0; j < 2; j++) begin
      for (int w = 0; w < 128; w++) begin
        access(j, 1, 32'(w * 8), 2'b11, {$urandom, $urandom});
      end
    end

    // Wrapping misaligned word write and out-of-range aliasing.
    access(0, 1, 32'h3FE, 2'b10, 64'hDEADBEEF);
    chk("t5_misalign", 64'(emis[0]), 64'd1);
    access(0, 0, 32'h001, 2'b00, 64'd0);
    chk("t5_byte1", last_w[0], 64'hDE);
    access(0, 0, 32'h400, 2'b00, 64'd0);
    chk("t5_alias", last_w[0], 64'hAD);
    chk("t5_range", 64'(erng[0]), 64'd1);

    // Abort: drop the read one edge after the request edge.
    addr_s[1] = 32'h20; sz_s[1] = 2'b11; rd_s[1] = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_ready", 64'(rdy[1]), 64'd0);
    chk("abort_drive", 64'(den[1]), 64'd0);
    rd_s[1] = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_ready_after", 64'(rdy[1]), 64'd0);
    check_state(1);
    @(posedge clk); #1;
    access(1, 0, 32'h20, 2'b11, 64'd0);

    // Read/write collision on both instances.
    conflict(0);
    conflict(1);
    access(0, 0, 32'h8, 2'b11, 64'd0);
    access(1, 0, 32'h8, 2'b11, 64'd0);

    // Randomised mixed traffic against the model.
    for (int j = 0; j < 80; j++) begin
      k  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) a = a & ~(32'(1 << sz) - 32'd1);
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 10);
      wd = {$urandom, $urandom};
      access(k, wr, a, sz, wd);
    end

    // Reset in the middle of a waited write.
    addr_s[1] = 32'h40; sz_s[1] = 2'b11; wv_s[1] = 64'hCAFEF00D12345678;
    drv_s[1] = 1; wr_s[1] = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    wr_s[1] = 0; drv_s[1] = 0;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    @(negedge clk);
    chk("reset_mid_ready", 64'(rdy[1]), 64'd0);
    check_state(0);
    check_state(1);
    @(posedge clk); #1;
    access(1, 0, 32'h40, 2'b11, 64'd0);
    access(0, 0, 32'h40, 2'b11, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
